// File: rtl/adc_avg_pkg.sv
// Shared types, widths and the rounding helper for the ADC sample averager.
package adc_avg_pkg;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int BLOCK_CNT_W = 16;

    // Round-half-up right shift; a zero shift passes the sum through untouched.
    function automatic logic [31:0] round_shift(input logic [31:0] sum, input int unsigned shift);
        logic [31:0] half;
        half = (shift == 0) ? 32'd0 : (32'd1 << (shift - 1));
        return (sum + half) >> shift;
    endfunction

endpackage

// File: rtl/ready_edge_detect.sv
// Rising-edge detector for the SAR ready level. The delay flop resets high so a
// level that is already asserted when reset releases does not look like an edge.
module ready_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_d_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_d_reg <= 1'b1;
        end else begin
            level_d_reg <= level;
        end
    end

    assign rise = level & ~level_d_reg;

endmodule

// File: rtl/adc_sample_averager.sv
// Accumulates 2^LOG2_SAMPLES ADC samples per block and publishes the rounded
// average, minimum and maximum of each completed block with a one-cycle strobe.
module adc_sample_averager
    import adc_avg_pkg::*;
#(
    parameter int RAMP_WIDTH   = 8,
    parameter int LOG2_SAMPLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RAMP_WIDTH-1:0]  adc_code,
    input  logic                   adc_ready,
    input  logic                   freeze,
    input  logic                   clear,
    output logic [RAMP_WIDTH-1:0]  avg_code,
    output logic [RAMP_WIDTH-1:0]  min_code,
    output logic [RAMP_WIDTH-1:0]  max_code,
    output logic                   avg_valid,
    output logic [BLOCK_CNT_W-1:0] block_cnt
);

    localparam int N     = 1 << LOG2_SAMPLES;
    localparam int CNT_W = (LOG2_SAMPLES == 0) ? 1 : LOG2_SAMPLES;
    localparam int ACC_W = RAMP_WIDTH + LOG2_SAMPLES;
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(N - 1);
    localparam logic [RAMP_WIDTH-1:0] CODE_ONES = '1;

    state_t                   state_reg, state_next;
    logic [ACC_W-1:0]         acc_reg, acc_next;
    logic [CNT_W-1:0]         smp_cnt_reg, smp_cnt_next;
    logic [RAMP_WIDTH-1:0]    run_min_reg, run_min_next;
    logic [RAMP_WIDTH-1:0]    run_max_reg, run_max_next;
    logic [RAMP_WIDTH-1:0]    avg_reg, avg_next;
    logic [RAMP_WIDTH-1:0]    min_reg, min_next;
    logic [RAMP_WIDTH-1:0]    max_reg, max_next;
    logic                     valid_reg, valid_next;
    logic [BLOCK_CNT_W-1:0]   block_cnt_reg, block_cnt_next;

    logic                     rise;
    logic                     accept;
    logic                     block_done;
    logic [ACC_W-1:0]         block_sum;
    logic [RAMP_WIDTH-1:0]    min_incl;
    logic [RAMP_WIDTH-1:0]    max_incl;

    ready_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .level (adc_ready),
        .rise  (rise)
    );

    assign accept     = rise & ~freeze & ~clear & (state_reg == ST_ACCUM);
    assign block_done = accept & (smp_cnt_reg == LAST_CNT);
    // The accumulator is sized so N full-scale codes cannot overflow it.
    assign block_sum  = acc_reg + ACC_W'(adc_code);
    assign min_incl   = (adc_code < run_min_reg) ? adc_code : run_min_reg;
    assign max_incl   = (adc_code > run_max_reg) ? adc_code : run_max_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ACCUM: if (freeze)  state_next = ST_HOLD;
            ST_HOLD:  if (!freeze) state_next = ST_ACCUM;
            default:  state_next = ST_ACCUM;
        endcase
    end

    always_comb begin
        acc_next       = acc_reg;
        smp_cnt_next   = smp_cnt_reg;
        run_min_next   = run_min_reg;
        run_max_next   = run_max_reg;
        avg_next       = avg_reg;
        min_next       = min_reg;
        max_next       = max_reg;
        valid_next     = 1'b0;
        block_cnt_next = block_cnt_reg;

        if (clear || block_done) begin
            acc_next     = '0;
            smp_cnt_next = '0;
            run_min_next = CODE_ONES;
            run_max_next = '0;
        end else if (accept) begin
            acc_next     = block_sum;
            smp_cnt_next = smp_cnt_reg + CNT_W'(1);
            run_min_next = min_incl;
            run_max_next = max_incl;
        end

        if (block_done) begin
            avg_next       = RAMP_WIDTH'(round_shift(32'(block_sum), LOG2_SAMPLES));
            min_next       = min_incl;
            max_next       = max_incl;
            valid_next     = 1'b1;
            block_cnt_next = block_cnt_reg + BLOCK_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_ACCUM;
            acc_reg       <= '0;
            smp_cnt_reg   <= '0;
            run_min_reg   <= CODE_ONES;
            run_max_reg   <= '0;
            avg_reg       <= '0;
            min_reg       <= '0;
            max_reg       <= '0;
            valid_reg     <= 1'b0;
            block_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            smp_cnt_reg   <= smp_cnt_next;
            run_min_reg   <= run_min_next;
            run_max_reg   <= run_max_next;
            avg_reg       <= avg_next;
            min_reg       <= min_next;
            max_reg       <= max_next;
            valid_reg     <= valid_next;
            block_cnt_reg <= block_cnt_next;
        end
    end

    assign avg_code  = avg_reg;
    assign min_code  = min_reg;
    assign max_code  = max_reg;
    assign avg_valid = valid_reg;
    assign block_cnt = block_cnt_reg;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Self-checking bench: a 16-sample build and a 1-sample build share the same
// stimulus and are compared every cycle against a queue-based block model.
module tb_adc_sample_averager;

    logic       clk = 1'b0;
    logic       reset;
    logic       adc_ready;
    logic       freeze;
    logic       clear;
    logic [7:0] adc_code;

    logic [7:0]  avg_a, min_a, max_a, avg_b, min_b, max_b;
    logic        valid_a, valid_b;
    logic [15:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    adc_sample_averager #(.RAMP_WIDTH(8), .LOG2_SAMPLES(4)) dut_a (
        .clk(clk), .reset(reset), .adc_code(adc_code), .adc_ready(adc_ready),
        .freeze(freeze), .clear(clear), .avg_code(avg_a), .min_code(min_a),
        .max_code(max_a), .avg_valid(valid_a), .block_cnt(cnt_a)
    );

    adc_sample_averager #(.RAMP_WIDTH(8), .LOG2_SAMPLES(0)) dut_b (
        .clk(clk), .reset(reset), .adc_code(adc_code), .adc_ready(adc_ready),
        .freeze(freeze), .clear(clear), .avg_code(avg_b), .min_code(min_b),
        .max_code(max_b), .avg_valid(valid_b), .block_cnt(cnt_b)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: accepted samples are queued; a full queue becomes a block.
    int q[2][$];
    int exp_avg[2], exp_min[2], exp_max[2], exp_cnt[2];
    bit exp_valid[2];
    bit m_prev_ready = 1'b1;
    bit m_prev_freeze = 1'b0;

    int valid_seen;
    int cap_avg, cap_min, cap_max;

    typedef struct {
        int base;
        int step;
        int e_avg;
        int e_min;
        int e_max;
    } blk_vec_t;

    blk_vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rise;
        bit acc;
        if (reset) begin
            for (int m = 0; m < 2; m++) begin
                q[m].delete();
                exp_avg[m] = 0; exp_min[m] = 0; exp_max[m] = 0;
                exp_cnt[m] = 0; exp_valid[m] = 1'b0;
            end
            m_prev_ready  = 1'b1;
            m_prev_freeze = 1'b0;
        end else begin
            rise = adc_ready && !m_prev_ready;
            // Frozen now, or frozen at the previous edge (still holding), blocks the edge.
            acc  = rise && !freeze && !m_prev_freeze && !clear;
            for (int m = 0; m < 2; m++) begin
                int n;
                n = (m == 0) ? 16 : 1;
                exp_valid[m] = 1'b0;
                if (clear) begin
                    q[m].delete();
                end else if (acc) begin
                    q[m].push_back(int'(adc_code));
                    if (q[m].size() == n) begin
                        int sum, mn, mx;
                        sum = 0; mn = 255; mx = 0;
                        foreach (q[m][k]) begin
                            sum += q[m][k];
                            if (q[m][k] < mn) mn = q[m][k];
                            if (q[m][k] > mx) mx = q[m][k];
                        end
                        exp_avg[m]   = (sum + n / 2) / n;
                        exp_min[m]   = mn;
                        exp_max[m]   = mx;
                        exp_valid[m] = 1'b1;
                        exp_cnt[m]   = (exp_cnt[m] + 1) % 65536;
                        q[m].delete();
                    end
                end
            end
            m_prev_ready  = adc_ready;
            m_prev_freeze = freeze;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("valid_n16", int'(valid_a), int'(exp_valid[0]));
        chk("avg_n16",   int'(avg_a),   exp_avg[0]);
        chk("min_n16",   int'(min_a),   exp_min[0]);
        chk("max_n16",   int'(max_a),   exp_max[0]);
        chk("cnt_n16",   int'(cnt_a),   exp_cnt[0]);
        chk("valid_n1",  int'(valid_b), int'(exp_valid[1]));
        chk("avg_n1",    int'(avg_b),   exp_avg[1]);
        chk("min_n1",    int'(min_b),   exp_min[1]);
        chk("max_n1",    int'(max_b),   exp_max[1]);
        chk("cnt_n1",    int'(cnt_b),   exp_cnt[1]);
        if (valid_a) begin
            valid_seen++;
            cap_avg = int'(avg_a);
            cap_min = int'(min_a);
            cap_max = int'(max_a);
        end
    endtask

    task automatic pulse(input int code, input int hi, input int lo);
        adc_code  = 8'(code);
        adc_ready = 1'b1;
        repeat (hi) tick();
        adc_ready = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        vecs[0] = '{base: 100, step: 0, e_avg: 100, e_min: 100, e_max: 100};
        vecs[1] = '{base: 0,   step: 1, e_avg: 8,   e_min: 0,   e_max: 15};
        vecs[2] = '{base: 255, step: 0, e_avg: 255, e_min: 255, e_max: 255};
        vecs[3] = '{base: 0,   step: 0, e_avg: 0,   e_min: 0,   e_max: 0};
        vecs[4] = '{base: 10,  step: 3, e_avg: 33,  e_min: 10,  e_max: 55};
        vecs[5] = '{base: 7,   step: 0, e_avg: 7,   e_min: 7,   e_max: 7};

        // Reset with ready already high; it must not count once reset releases.
        reset = 1'b1; adc_ready = 1'b1; freeze = 1'b0; clear = 1'b0; adc_code = 8'd77;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_avg", int'(avg_a), 0);
        chk("reset_min", int'(min_a), 0);
        chk("reset_max", int'(max_a), 0);
        chk("reset_valid", int'(valid_a), 0);
        chk("reset_cnt", int'(cnt_a), 0);
        repeat (3) tick();
        adc_ready = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            valid_seen = 0;
            for (int s = 0; s < 16; s++) pulse(vecs[i].base + s * vecs[i].step, 1, 1);
            chk("tbl_valid_pulses", valid_seen, 1);
            chk("tbl_avg", cap_avg, vecs[i].e_avg);
            chk("tbl_min", cap_min, vecs[i].e_min);
            chk("tbl_max", cap_max, vecs[i].e_max);
            chk("tbl_block_cnt", int'(cnt_a), i + 1);
            chk("tbl_n1_avg", int'(avg_b), vecs[i].base + 15 * vecs[i].step);
        end

        // Ready held high for 10 cycles counts once per pulse.
        valid_seen = 0;
        for (int s = 0; s < 16; s++) pulse(33, 10, 1);
        chk("held_valid_pulses", valid_seen, 1);
        chk("held_avg", cap_avg, 33);

        // Edges while frozen are lost; the block finishes on the 16th accepted sample.
        valid_seen = 0;
        for (int s = 0; s < 8; s++) pulse(20, 1, 1);
        freeze = 1'b1;
        for (int s = 0; s < 5; s++) pulse(200, 1, 1);
        freeze = 1'b0;
        tick();
        for (int s = 0; s < 7; s++) pulse(40, 1, 1);
        chk("freeze_early_valid", valid_seen, 0);
        pulse(40, 1, 1);
        chk("freeze_valid_pulses", valid_seen, 1);
        chk("freeze_avg", cap_avg, 30);
        chk("freeze_min", cap_min, 20);
        chk("freeze_max", cap_max, 40);

        // Clear coincident with the 4th edge drops it and flushes the partial block.
        for (int s = 0; s < 3; s++) pulse(50, 1, 1);
        clear = 1'b1; adc_code = 8'd250; adc_ready = 1'b1;
        tick();
        clear = 1'b0; adc_ready = 1'b0;
        tick();
        valid_seen = 0;
        for (int s = 0; s < 15; s++) pulse(60, 1, 1);
        chk("clear_early_valid", valid_seen, 0);
        pulse(60, 1, 1);
        chk("clear_valid_pulses", valid_seen, 1);
        chk("clear_avg", cap_avg, 60);
        chk("clear_min", cap_min, 60);

        // Reset mid-block discards everything.
        for (int s = 0; s < 10; s++) pulse(90, 1, 1);
        reset = 1'b1;
        repeat (2) tick();
        chk("midreset_avg", int'(avg_a), 0);
        chk("midreset_max", int'(max_a), 0);
        chk("midreset_cnt", int'(cnt_a), 0);
        reset = 1'b0;
        tick();
        valid_seen = 0;
        for (int s = 0; s < 16; s++) pulse(7, 1, 1);
        chk("midreset_valid_pulses", valid_seen, 1);
        chk("midreset_new_avg", cap_avg, 7);
        chk("midreset_new_cnt", int'(cnt_a), 1);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            adc_ready = 1'($urandom_range(0, 1));
            adc_code  = 8'($urandom_range(0, 255));
            freeze    = ($urandom_range(0, 11) == 0);
            clear     = ($urandom_range(0, 39) == 0);
            tick();
        end
        freeze = 1'b0; clear = 1'b0; adc_ready = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
